// File: rtl/req_gnt_pkg.sv
// req_gnt_pkg: shared types and helpers for the req/gnt responder.
//   state_e   : responder FSM states (IDLE = no owner, GRANT = owner holds gnt)
//   id_width  : width of an owner index for a given requester count
package req_gnt_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Index width for n requesters; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/req_gnt_responder_rr_pick.sv
// rr_pick: combinational round-robin priority picker.
//   req    in  N     request vector
//   ptr    in  ID_W  index where the search starts (wraps modulo N)
//   excl   in  N     requesters that may not win
//   found  out 1     some eligible requester exists
//   winner out ID_W  first eligible index at or after ptr
module rr_pick
    import req_gnt_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = id_width(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    input  logic [N-1:0]    excl,
    output logic            found,
    output logic [ID_W-1:0] winner
);

    logic [N-1:0]   w_elig;
    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;

    // Rotate the eligible set so that bit 0 corresponds to ptr.
    assign w_elig = req & ~excl;
    assign w_dbl  = {w_elig, w_elig};
    assign w_rot  = N'(w_dbl >> ptr);

    // Lowest rotated offset wins; scanning downward lets the last hit stand.
    always_comb begin
        int unsigned v_sum;
        found  = 1'b0;
        winner = '0;
        v_sum  = 0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                found = 1'b1;
                v_sum = 32'(ptr) + 32'(i);
                if (v_sum >= N) begin
                    v_sum = v_sum - N;
                end
                winner = ID_W'(v_sum);
            end
        end
    end

endmodule

// File: rtl/req_gnt_responder.sv
// req_gnt_responder: round-robin grant-side responder for the req/gnt handshake.
// A sampled request is answered with a registered one-hot grant one clock later;
// an owner is rotated out after MAX_HOLD cycles only when someone else waits.
//   clk     in   1        rising-edge clock
//   rst_n   in   1        asynchronous active-low reset
//   req     in   NUM_REQ  request levels
//   gnt     out  NUM_REQ  registered one-hot-or-zero grant
//   gnt_id  out  ID_W     current owner index (valid while busy)
//   busy    out  1        OR of gnt
// Optional: define REQ_GNT_SVA_EN to compile embedded handshake assertions.
module req_gnt_responder
    import req_gnt_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [id_width(NUM_REQ)-1:0]  gnt_id,
    output logic                          busy
);

    localparam int unsigned ID_W = id_width(NUM_REQ);
    localparam int unsigned HC_W = $clog2(MAX_HOLD + 1);

    state_e             r_state, w_state_n;
    logic [ID_W-1:0]    r_ptr, w_ptr_n;
    logic [HC_W-1:0]    r_hold, w_hold_n;
    logic [NUM_REQ-1:0] r_gnt, w_gnt_n;
    logic [ID_W-1:0]    r_gnt_id, w_gnt_id_n;

    logic               w_found;
    logic [ID_W-1:0]    w_win;
    logic [ID_W-1:0]    w_win_next;
    logic               w_owner_req;
    logic               w_can_hold;
    logic               w_take;

    // The current owner is excluded so a forced rotation picks someone else;
    // in IDLE r_gnt is zero and nobody is excluded.
    rr_pick #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_pick (
        .req    (req),
        .ptr    (r_ptr),
        .excl   (r_gnt),
        .found  (w_found),
        .winner (w_win)
    );

    assign w_owner_req = |(req & r_gnt);
    assign w_can_hold  = (r_hold < HC_W'(MAX_HOLD));
    assign w_win_next  = (32'(w_win) + 32'd1 >= NUM_REQ) ? '0 : ID_W'(32'(w_win) + 32'd1);

    // State and grant registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_hold   <= '0;
            r_gnt    <= '0;
            r_gnt_id <= '0;
        end else begin
            r_state  <= w_state_n;
            r_ptr    <= w_ptr_n;
            r_hold   <= w_hold_n;
            r_gnt    <= w_gnt_n;
            r_gnt_id <= w_gnt_id_n;
        end
    end

    // Next-state: keep, rotate/hand over (w_take), or release to IDLE.
    always_comb begin
        w_state_n  = r_state;
        w_ptr_n    = r_ptr;
        w_hold_n   = r_hold;
        w_gnt_n    = r_gnt;
        w_gnt_id_n = r_gnt_id;
        w_take     = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_take = 1'b1;
                end
            end
            GRANT: begin
                if (w_owner_req) begin
                    if (!w_can_hold && w_found) begin
                        w_take = 1'b1;
                    end else if (w_can_hold) begin
                        w_hold_n = r_hold + HC_W'(1);
                    end
                end else if (w_found) begin
                    w_take = 1'b1;
                end else begin
                    w_state_n = IDLE;
                    w_gnt_n   = '0;
                    w_hold_n  = '0;
                end
            end
            default: begin
                w_state_n = IDLE;
                w_gnt_n   = '0;
                w_hold_n  = '0;
            end
        endcase

        if (w_take) begin
            w_state_n  = GRANT;
            w_gnt_n    = NUM_REQ'(1) << w_win;
            w_gnt_id_n = w_win;
            w_hold_n   = HC_W'(1);
            w_ptr_n    = w_win_next;
        end
    end

    assign gnt    = r_gnt;
    assign gnt_id = r_gnt_id;
    assign busy   = |r_gnt;

`ifdef REQ_GNT_SVA_EN
    a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));

    for (genvar gi = 0; gi < int'(NUM_REQ); gi++) begin : g_sva
        a_req_before: assert property (@(posedge clk) disable iff (!rst_n)
            gnt[gi] |-> $past(req[gi]));
        // Only an uncontended idle request is guaranteed the next-cycle grant.
        a_idle_gnt: assert property (@(posedge clk) disable iff (!rst_n)
            (req[gi] && !busy && ((req & ~(NUM_REQ'(1) << gi)) == '0)) |=> gnt[gi]);
        a_hold: assert property (@(posedge clk) disable iff (!rst_n)
            (gnt[gi] && req[gi] && (r_hold < HC_W'(MAX_HOLD))) |=> gnt[gi]);
    end
`endif

endmodule
